// File: rtl/calorie_stream_ctrl.sv
// Streaming group-sum controller: accumulates records into per-group sums,
// keeps a sorted top-3 set and reports the largest sum and the top-3 total.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | after reset; waits for start, no records accepted
// ACCUM  | accepting records, summing the current group
// INSERT | one cycle: rank the finished group sum into top1..top3
// FINAL  | one cycle: latch out_max and saturated top-3 total
// DONE   | results held; start begins a new run
module calorie_stream_ctrl #(
    parameter int W  = 32,
    parameter int OW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_sep,
    input  logic          in_eof,
    output logic          busy,
    output logic          done,
    output logic [OW-1:0] out_max,
    output logic [OW-1:0] out_top3,
    output logic          overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_INSERT,
        S_FINAL,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] sum_q, sum_d;
    logic [OW-1:0] top1_q, top1_d;
    logic [OW-1:0] top2_q, top2_d;
    logic [OW-1:0] top3_q, top3_d;
    logic [OW-1:0] out_max_q, out_max_d;
    logic [OW-1:0] out_top3_q, out_top3_d;
    logic          overflow_q, overflow_d;
    logic          eof_pend_q, eof_pend_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          xfer;
    logic          sum_nz;
    logic [OW:0]   sum_ext;
    logic [OW+1:0] top_total;
    logic          top_sat;

    assign xfer      = in_valid && in_ready_q;
    assign sum_nz    = (sum_q != '0);
    assign sum_ext   = {1'b0, sum_q} + {1'b0, OW'(in_data)};
    assign top_total = {2'b00, top1_q} + {2'b00, top2_q} + {2'b00, top3_q};
    assign top_sat   = (top_total[OW+1:OW] != 2'b00);

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        top1_d     = top1_q;
        top2_d     = top2_q;
        top3_d     = top3_q;
        out_max_d  = out_max_q;
        out_top3_d = out_top3_q;
        overflow_d = overflow_q;
        eof_pend_d = eof_pend_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_ACCUM;
                    sum_d      = '0;
                    top1_d     = '0;
                    top2_d     = '0;
                    top3_d     = '0;
                    out_max_d  = '0;
                    out_top3_d = '0;
                    overflow_d = 1'b0;
                    eof_pend_d = 1'b0;
                end
            end
            S_ACCUM: begin
                if (xfer) begin
                    // eof wins over sep when both are flagged
                    if (in_eof) begin
                        eof_pend_d = 1'b1;
                        state_d    = sum_nz ? S_INSERT : S_FINAL;
                    end else if (in_sep) begin
                        if (sum_nz) begin
                            state_d = S_INSERT;
                        end
                    end else if (sum_ext[OW]) begin
                        sum_d      = '1;
                        overflow_d = 1'b1;
                    end else begin
                        sum_d = sum_ext[OW-1:0];
                    end
                end
            end
            S_INSERT: begin
                // strict compares: an equal sum lands below its twin
                if (sum_q > top1_q) begin
                    top3_d = top2_q;
                    top2_d = top1_q;
                    top1_d = sum_q;
                end else if (sum_q > top2_q) begin
                    top3_d = top2_q;
                    top2_d = sum_q;
                end else if (sum_q > top3_q) begin
                    top3_d = sum_q;
                end
                sum_d   = '0;
                state_d = eof_pend_q ? S_FINAL : S_ACCUM;
            end
            S_FINAL: begin
                out_max_d = top1_q;
                if (top_sat) begin
                    out_top3_d = '1;
                    overflow_d = 1'b1;
                end else begin
                    out_top3_d = top_total[OW-1:0];
                end
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_ACCUM);
        busy_d     = (state_d == S_ACCUM) || (state_d == S_INSERT) || (state_d == S_FINAL);
        // done trails entry into DONE by one cycle and drops on restart
        done_d     = (state_q == S_DONE) && !start;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sum_q      <= '0;
            top1_q     <= '0;
            top2_q     <= '0;
            top3_q     <= '0;
            out_max_q  <= '0;
            out_top3_q <= '0;
            overflow_q <= 1'b0;
            eof_pend_q <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            top1_q     <= top1_d;
            top2_q     <= top2_d;
            top3_q     <= top3_d;
            out_max_q  <= out_max_d;
            out_top3_q <= out_top3_d;
            overflow_q <= overflow_d;
            eof_pend_q <= eof_pend_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign out_max  = out_max_q;
    assign out_top3 = out_top3_q;
    assign overflow = overflow_q;

endmodule
